// File: rtl/prof_probe_source.sv
// rtl/prof_probe_source.sv - turns stamp/stop event strobes into p0 pipe command words
// through a small FIFO with a slot reserved for the stop word.
module prof_probe_source #(
    parameter int DEPTH = 8
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   enable,
    input  logic                   stamp_req,
    input  logic                   stop_req,
    input  logic                   clear,
    output logic [31:0]            p0_TDATA,
    output logic                   p0_TVALID,
    input  logic                   p0_TREADY,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [15:0]            dropped_count,
    output logic                   stopped,
    output logic                   done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_STAMP = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] P_ONE   = AW'(1);

    // Only two command words exist, so each entry just records whether it is the stop word.
    logic [DEPTH-1:0] r_is_stop;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             r_overflow;
    logic [15:0]      r_dropped;
    logic             r_stopped;
    logic             r_stop_pending;
    logic             r_done;

    logic        w_clear_eff;
    logic        w_active;
    logic        w_stamp_ok;
    logic        w_stamp_drop;
    logic        w_stop_set;
    logic        w_stop_push;
    logic        w_push;
    logic        w_pop;
    logic        w_pending_nxt;
    logic        w_stopped_nxt;
    logic [AW:0] w_level_nxt;

    always_comb begin
        w_clear_eff   = clear && r_done;
        w_active      = enable && !r_stopped && !r_stop_pending && !w_clear_eff;
        w_stamp_ok    = stamp_req && w_active && (r_level < L_STAMP);
        w_stamp_drop  = stamp_req && w_active && !(r_level < L_STAMP);
        w_stop_set    = stop_req && w_active;
        w_stop_push   = r_stop_pending && !w_stamp_ok && (r_level < L_FULL);
        w_push        = w_stamp_ok || w_stop_push;
        w_pop         = (r_level != '0) && p0_TREADY;
        w_level_nxt   = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + L_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - L_ONE;
        end
        w_pending_nxt = (r_stop_pending && !w_stop_push) || w_stop_set;
        w_stopped_nxt = !w_clear_eff && (r_stopped || w_stop_push);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_is_stop      <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_overflow     <= 1'b0;
            r_dropped      <= 16'd0;
            r_stopped      <= 1'b0;
            r_stop_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (w_push) begin
                r_is_stop[r_wptr] <= w_stop_push;
                r_wptr            <= r_wptr + P_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + P_ONE;
            end
            r_level        <= w_level_nxt;
            r_stop_pending <= w_pending_nxt;
            r_stopped      <= w_stopped_nxt;
            r_done         <= w_stopped_nxt && (w_level_nxt == '0) && !w_pending_nxt;
            if (w_clear_eff) begin
                r_overflow <= 1'b0;
                r_dropped  <= 16'd0;
            end else if (w_stamp_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != 16'hFFFF) begin
                    r_dropped <= r_dropped + 16'd1;
                end
            end
        end
    end

    assign p0_TVALID     = (r_level != '0);
    assign p0_TDATA      = !p0_TVALID ? 32'd0 : (r_is_stop[r_rptr] ? 32'd2 : 32'd1);
    assign level         = r_level;
    assign overflow      = r_overflow;
    assign dropped_count = r_dropped;
    assign stopped       = r_stopped;
    assign done          = r_done;
endmodule

// File: tb/tb_prof_probe_source.sv
// tb/tb_prof_probe_source.sv - bench for prof_probe_source: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_prof_probe_source;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          ap_clk    = 1'b0;
    logic          ap_rst    = 1'b1;
    logic          enable    = 1'b0;
    logic          stamp_req = 1'b0;
    logic          stop_req  = 1'b0;
    logic          clear     = 1'b0;
    logic          p0_TREADY = 1'b0;
    logic [31:0]   p0_TDATA;
    logic          p0_TVALID;
    logic [LW-1:0] level;
    logic          overflow;
    logic [15:0]   dropped_count;
    logic          stopped;
    logic          done;

    int checks   = 0;
    int failures = 0;

    int unsigned m_q[$];
    bit          m_stopped, m_pending, m_overflow, m_done;
    int          m_dropped;

    typedef struct {
        logic [4:0]  in;
        logic        valid;
        logic [31:0] data;
        int          lvl;
        logic [1:0]  fl;
    } vec_t;
    vec_t tbl[11];

    always #5 ap_clk = ~ap_clk;

    prof_probe_source #(.DEPTH(DEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .enable(enable), .stamp_req(stamp_req),
        .stop_req(stop_req), .clear(clear), .p0_TDATA(p0_TDATA), .p0_TVALID(p0_TVALID),
        .p0_TREADY(p0_TREADY), .level(level), .overflow(overflow),
        .dropped_count(dropped_count), .stopped(stopped), .done(done)
    );

    function automatic vec_t mk(input logic [4:0] in, input logic v, input logic [31:0] d,
                                input int l, input logic [1:0] fl);
        vec_t r;
        r.in = in; r.valid = v; r.data = d; r.lvl = l; r.fl = fl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_stopped = 0; m_pending = 0; m_overflow = 0; m_done = 0; m_dropped = 0;
    endtask

    // One clock of the command-pipe rules, applied to the current inputs.
    task automatic model_step(input bit en, input bit st, input bit sp, input bit cl, input bit rd);
        bit clr_eff, act, stamp_ok, stop_push, do_pop;
        clr_eff   = cl && m_done;
        act       = en && !m_stopped && !m_pending && !clr_eff;
        stamp_ok  = st && act && (m_q.size() < DEPTH - 1);
        stop_push = m_pending && !stamp_ok && (m_q.size() < DEPTH);
        do_pop    = (m_q.size() > 0) && rd;
        if (do_pop) void'(m_q.pop_front());
        if (stamp_ok) m_q.push_back(1);
        else if (st && act) begin
            m_overflow = 1;
            if (m_dropped < 65535) m_dropped++;
        end
        if (stop_push) begin
            m_q.push_back(2);
            m_pending = 0;
            m_stopped = 1;
        end
        if (sp && act) m_pending = 1;
        if (clr_eff) begin
            m_stopped = 0; m_overflow = 0; m_dropped = 0;
        end
        m_done = m_stopped && (m_q.size() == 0) && !m_pending;
    endtask

    task automatic apply(input bit en, input bit st, input bit sp, input bit cl, input bit rd);
        enable = en; stamp_req = st; stop_req = sp; clear = cl; p0_TREADY = rd;
        model_step(en, st, sp, cl, rd);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},   32'(p0_TVALID), 32'(m_q.size() > 0));
        chk({tag, ".data"},    p0_TDATA, (m_q.size() > 0) ? m_q[0] : 32'd0);
        chk({tag, ".level"},   32'(level), 32'(m_q.size()));
        chk({tag, ".ovf"},     32'(overflow), 32'(m_overflow));
        chk({tag, ".dropped"}, 32'(dropped_count), 32'(m_dropped));
        chk({tag, ".stopped"}, 32'(stopped), 32'(m_stopped));
        chk({tag, ".done"},    32'(done), 32'(m_done));
    endtask

    task automatic do_reset();
        enable = 0; stamp_req = 0; stop_req = 0; clear = 0; p0_TREADY = 0;
        ap_rst = 1;
        model_reset();
        @(posedge ap_clk);
        #1;
        ap_rst = 0;
    endtask

    initial begin
        logic [31:0] got[$];
        bit en, st, sp, cl, rd;

        // inputs {en, stamp, stop, clear, ready}; flags {stopped, done}
        tbl[0]  = mk(5'b11001, 1'b1, 32'd1, 1, 2'b00);
        tbl[1]  = mk(5'b10001, 1'b0, 32'd0, 0, 2'b00);
        tbl[2]  = mk(5'b11001, 1'b1, 32'd1, 1, 2'b00);
        tbl[3]  = mk(5'b11001, 1'b1, 32'd1, 1, 2'b00);
        tbl[4]  = mk(5'b10101, 1'b0, 32'd0, 0, 2'b00);
        tbl[5]  = mk(5'b10001, 1'b1, 32'd2, 1, 2'b10);
        tbl[6]  = mk(5'b10001, 1'b0, 32'd0, 0, 2'b11);
        tbl[7]  = mk(5'b11001, 1'b0, 32'd0, 0, 2'b11);
        tbl[8]  = mk(5'b10011, 1'b0, 32'd0, 0, 2'b00);
        tbl[9]  = mk(5'b11001, 1'b1, 32'd1, 1, 2'b00);
        tbl[10] = mk(5'b10001, 1'b0, 32'd0, 0, 2'b00);

        do_reset();
        chk("rst.valid",   32'(p0_TVALID), 32'd0);
        chk("rst.data",    p0_TDATA, 32'd0);
        chk("rst.level",   32'(level), 32'd0);
        chk("rst.ovf",     32'(overflow), 32'd0);
        chk("rst.dropped", 32'(dropped_count), 32'd0);
        chk("rst.stopped", 32'(stopped), 32'd0);
        chk("rst.done",    32'(done), 32'd0);

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            chk($sformatf("tbl%0d.valid", i),   32'(p0_TVALID), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d.data", i),    p0_TDATA, tbl[i].data);
            chk($sformatf("tbl%0d.level", i),   32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d.stopped", i), 32'(stopped), 32'(tbl[i].fl[1]));
            chk($sformatf("tbl%0d.done", i),    32'(done), 32'(tbl[i].fl[0]));
        end

        // Overflow with the sink stalled, then a stop into the reserved slot.
        do_reset();
        for (int i = 0; i < 10; i++) apply(1, 1, 0, 0, 0);
        chk("ovf.level",   32'(level), 32'd7);
        chk("ovf.flag",    32'(overflow), 32'd1);
        chk("ovf.dropped", 32'(dropped_count), 32'd3);
        apply(1, 0, 1, 0, 0);
        chk("ovf.pend_level", 32'(level), 32'd7);
        apply(1, 0, 0, 0, 0);
        chk("ovf.stop_level", 32'(level), 32'd8);
        chk("ovf.stopped",    32'(stopped), 32'd1);
        apply(1, 0, 0, 1, 0);
        chk("early_clear.stopped", 32'(stopped), 32'd1);
        chk("early_clear.ovf",     32'(overflow), 32'd1);
        chk("early_clear.dropped", 32'(dropped_count), 32'd3);
        got.delete();
        for (int c = 0; c < 30 && got.size() < 8; c++) begin
            if (p0_TVALID) got.push_back(p0_TDATA);
            apply(1, 0, 0, 0, 1);
        end
        chk("ovf.words", 32'(got.size()), 32'd8);
        foreach (got[i]) chk($sformatf("ovf.word%0d", i), got[i], (i < 7) ? 32'd1 : 32'd2);
        chk("ovf.done", 32'(done), 32'd1);

        // Stamp and stop in the same cycle.
        do_reset();
        apply(1, 1, 1, 0, 0);
        chk("sim.level1", 32'(level), 32'd1);
        chk("sim.head",   p0_TDATA, 32'd1);
        apply(1, 0, 0, 0, 0);
        chk("sim.level2", 32'(level), 32'd2);
        got.delete();
        for (int c = 0; c < 10 && got.size() < 2; c++) begin
            if (p0_TVALID) got.push_back(p0_TDATA);
            apply(1, 0, 0, 0, 1);
        end
        chk("sim.words", 32'(got.size()), 32'd2);
        foreach (got[i]) chk($sformatf("sim.word%0d", i), got[i], (i == 0) ? 32'd1 : 32'd2);
        for (int i = 0; i < 3; i++) apply(1, 1, 0, 0, 1);
        chk("sim.dropped", 32'(dropped_count), 32'd0);
        chk("sim.level",   32'(level), 32'd0);
        chk("sim.done",    32'(done), 32'd1);

        // Asynchronous reset with five words queued.
        do_reset();
        for (int i = 0; i < 5; i++) apply(1, 1, 0, 0, 0);
        chk("mid.level_before", 32'(level), 32'd5);
        #2;
        ap_rst = 1;
        #1;
        chk("mid.valid", 32'(p0_TVALID), 32'd0);
        chk("mid.level", 32'(level), 32'd0);
        chk("mid.data",  p0_TDATA, 32'd0);
        model_reset();
        @(posedge ap_clk);
        #1;
        ap_rst = 0;
        apply(1, 1, 0, 0, 0);
        chk("mid.after_level", 32'(level), 32'd1);
        chk("mid.after_data",  p0_TDATA, 32'd1);

        // Randomized traffic with random back-pressure against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 1) == 1);
            sp = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 5) == 0);
            rd = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            apply(en, st, sp, cl, rd);
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
